// File: rtl/ocp_axi_rd_resp_conv_p.sv
// OCP read-response packet to AXI R-channel burst converter.
// Whole packets are buffered in a DEPTH-entry packet FIFO and then played out
// one beat per R handshake. Back-to-back bursts run with no idle cycle.
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   ocp_resp_*        : packet input (vld, id, len = beats-1, err, data)
//   ocp_resp_hold     : FIFO full; the producer must hold its packet
//   rvalid/rready     : AXI R handshake
//   rid/rdata/rresp/rlast : AXI R payload
//   fifo_level        : packets waiting in the FIFO (excludes the one in flight)
module ocp_axi_rd_resp_conv_p #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LEN_W     = $clog2(MAX_BEATS),
  parameter int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ocp_resp_vld,
  input  logic [ID_W-1:0]             ocp_resp_id,
  input  logic [LEN_W-1:0]            ocp_resp_len,
  input  logic                        ocp_resp_err,
  input  logic [MAX_BEATS*DATA_W-1:0] ocp_resp_data,
  output logic                        ocp_resp_hold,
  output logic                        rvalid,
  input  logic                        rready,
  output logic [ID_W-1:0]             rid,
  output logic [DATA_W-1:0]           rdata,
  output logic [1:0]                  rresp,
  output logic                        rlast,
  output logic [CNT_W-1:0]            fifo_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned PKT_W = MAX_BEATS * DATA_W;

  typedef enum logic {IDLE, BURST} state_t;

  // Packet FIFO storage (no reset: contents are qualified by count)
  logic [ID_W-1:0]  mem_id   [DEPTH];
  logic [LEN_W-1:0] mem_len  [DEPTH];
  logic             mem_err  [DEPTH];
  logic [PKT_W-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  state_t           state;
  logic [LEN_W-1:0] beat;
  logic [LEN_W-1:0] beat_nxt;
  logic [LEN_W-1:0] pkt_len;
  logic [DATA_W-1:0] pkt_data [MAX_BEATS];

  assign full          = (count == CNT_W'(DEPTH));
  assign empty         = (count == '0);
  assign ocp_resp_hold = full;
  assign fifo_level    = count;
  assign push          = ocp_resp_vld & ~full;
  // Pop when idle, or on the last-beat handshake so the next burst follows directly
  assign pop           = ~empty & ((state == IDLE) | ((state == BURST) & rvalid & rready & rlast));
  assign beat_nxt      = beat + LEN_W'(1);

  // FIFO write port
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]   <= ocp_resp_id;
      mem_len[wr_ptr]  <= ocp_resp_len;
      mem_err[wr_ptr]  <= ocp_resp_err;
      mem_data[wr_ptr] <= ocp_resp_data;
    end
  end

  // FIFO pointers and occupancy; a refused push while full is never retried internally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Beat buffer for the packet being serialised
  always_ff @(posedge clk) begin
    if (pop) begin
      for (int k = 0; k < int'(MAX_BEATS); k++) begin
        pkt_data[k] <= mem_data[rd_ptr][k*DATA_W +: DATA_W];
      end
    end
  end

  // Serialiser FSM with registered R-channel outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      beat    <= '0;
      pkt_len <= '0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= 2'b00;
    end else begin
      if (pop) begin
        state   <= BURST;
        beat    <= '0;
        pkt_len <= mem_len[rd_ptr];
        rvalid  <= 1'b1;
        rid     <= mem_id[rd_ptr];
        rdata   <= mem_data[rd_ptr][DATA_W-1:0];
        rresp   <= mem_err[rd_ptr] ? 2'b10 : 2'b00;
        rlast   <= (mem_len[rd_ptr] == '0);
      end else begin
        case (state)
          IDLE: begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
          end
          BURST: begin
            if (rvalid && rready) begin
              if (!rlast) begin
                beat  <= beat_nxt;
                rdata <= pkt_data[beat_nxt];
                rlast <= (beat_nxt == pkt_len);
              end else begin
                state  <= IDLE;
                rvalid <= 1'b0;
                rlast  <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
